// File: rtl/dht11_response_builder.sv
// dht11_response_builder
// Accepts a one-byte command, runs one DHT11 sensor transaction, validates the
// 40-bit frame and returns a two-byte response (code, data) over valid/ready.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   command[7:0]         0x00 status, 0x01 temperature, 0x02 humidity
//   command_valid        one-cycle strobe, honoured only while idle
//   sensor_data[39:0]    raw frame; bit 0 is the first bit on the wire
//   sensor_hold          sensor transaction in progress (informational only)
//   sensor_error         sensor protocol error
//   sensor_done          sensor "data may be sent" flag
//   sensor_enable        sensor block enable (Moore, decoded from state)
//   sensor_reset         sensor block reset  (Moore, decoded from state)
//   tx_data[7:0]         response byte
//   tx_valid / tx_ready  response handshake
//   busy                 high whenever not idle
//
// Build option: define DHT11_CHECKSUM_CHECK_EN to enforce the frame checksum
// (mismatch answers 0xEF). Without it the checksum bytes are never examined.
module dht11_response_builder #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  command,
  input  logic        command_valid,
  input  logic [39:0] sensor_data,
  input  logic        sensor_hold,
  input  logic        sensor_error,
  input  logic        sensor_done,
  output logic        sensor_enable,
  output logic        sensor_reset,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, START_SENSOR, WAIT_SENSOR, EVALUATE, SEND_CODE, SEND_DATA
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [7:0]       hum_q, hum_d;
  logic [7:0]       temp_q, temp_d;
  logic             err_q, err_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       data_q, data_d;

  // Frame bytes arrive MSB-first on the wire, so each byte is bit-reversed.
  function automatic logic [7:0] wire_byte(input logic [7:0] raw);
    logic [7:0] res;
    for (int i = 0; i < 8; i++) res[7-i] = raw[i];
    return res;
  endfunction

`ifdef DHT11_CHECKSUM_CHECK_EN
  logic       csum_bad_q, csum_bad_d;
  logic [7:0] csum_c;
  logic       unused_sig;

  // 8-bit wrapping sum of bytes 0..3 against byte 4.
  assign csum_c = wire_byte(sensor_data[7:0])   + wire_byte(sensor_data[15:8]) +
                  wire_byte(sensor_data[23:16]) + wire_byte(sensor_data[31:24]);
  assign unused_sig = sensor_hold;
`else
  logic [24:0] unused_sig;
  assign unused_sig = {sensor_hold, sensor_data[39:24], sensor_data[15:8]};
`endif

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= 2'd0;
      hum_q   <= 8'h00;
      temp_q  <= 8'h00;
      err_q   <= 1'b0;
      code_q  <= 8'h00;
      data_q  <= 8'h00;
`ifdef DHT11_CHECKSUM_CHECK_EN
      csum_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      hum_q   <= hum_d;
      temp_q  <= temp_d;
      err_q   <= err_d;
      code_q  <= code_d;
      data_q  <= data_d;
`ifdef DHT11_CHECKSUM_CHECK_EN
      csum_bad_q <= csum_bad_d;
`endif
    end
  end

  // Next-state, datapath updates and Moore output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    hum_d   = hum_q;
    temp_d  = temp_q;
    err_d   = err_q;
    code_d  = code_q;
    data_d  = data_q;
`ifdef DHT11_CHECKSUM_CHECK_EN
    csum_bad_d = csum_bad_q;
`endif
    sensor_enable = 1'b0;
    sensor_reset  = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    busy          = 1'b1;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (command_valid) begin
          if (command <= 8'h02) begin
            cmd_d   = command[1:0];
            state_d = START_SENSOR;
          end else begin
            // Unknown request: answer immediately without touching the sensor.
            code_d  = 8'hFF;
            data_d  = 8'h00;
            state_d = SEND_CODE;
          end
        end
      end
      START_SENSOR: begin
        sensor_enable = 1'b1;
        sensor_reset  = 1'b1;
        cnt_d         = '0;
        state_d       = WAIT_SENSOR;
      end
      WAIT_SENSOR: begin
        sensor_enable = 1'b1;
        // cnt_q == 0 marks the first wait cycle, where a stale done is ignored.
        if (sensor_done && (cnt_q != '0)) begin
          hum_d   = wire_byte(sensor_data[7:0]);
          temp_d  = wire_byte(sensor_data[23:16]);
          err_d   = sensor_error;
`ifdef DHT11_CHECKSUM_CHECK_EN
          csum_bad_d = (csum_c != wire_byte(sensor_data[39:32]));
`endif
          state_d = EVALUATE;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = 8'h1E;
          data_d  = 8'h00;
          state_d = SEND_CODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EVALUATE: begin
        state_d = SEND_CODE;
        data_d  = 8'h00;
        if (err_q) begin
          code_d = 8'h1F;
`ifdef DHT11_CHECKSUM_CHECK_EN
        end else if (csum_bad_q) begin
          code_d = 8'hEF;
`endif
        end else begin
          case (cmd_q)
            2'd0:    code_d = 8'h08;
            2'd1:    begin code_d = 8'h09; data_d = temp_q; end
            default: begin code_d = 8'h0A; data_d = hum_q;  end
          endcase
        end
      end
      SEND_CODE: begin
        tx_valid = 1'b1;
        tx_data  = code_q;
        if (tx_ready) state_d = SEND_DATA;
      end
      SEND_DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_q;
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/dht11_response_builder.md
# dht11_response_builder

Downstream stage of the DHT11 communication block. It accepts a one-byte command from the command decoder and starts one DHT11 transaction by pulsing the sensor's enable and reset inputs. It then waits for the sensor-side "data may be sent" flag, validates the 40-bit frame, and emits a two-byte response (code byte, then data byte) to the UART transmitter over a valid/ready handshake.

## Interface
Parameters:
- TIMEOUT_CYCLES, 5_000_000: maximum cycles spent in WAIT_SENSOR (100 ms at 50 MHz) before reporting a timeout.

Ports:
- clock  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high; one clock, no other clock domains.
- command  input  8  request code: 0x00 status, 0x01 temperature, 0x02 humidity.
- command_valid  input  1  one-cycle strobe; sampled only in IDLE.
- sensor_data  input  40  raw frame; bit 0 is the first bit received on the wire.
- sensor_hold  input  1  sensor transaction in progress.
- sensor_error  input  1  sensor reported a protocol error.
- sensor_done  input  1  sensor's "data may be sent" flag.
- sensor_enable  output  1  drives the sensor block's enable_sensor.
- sensor_reset  output  1  drives the sensor block's reset.
- tx_data  output  8  response byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART transmitter accepts the byte.
- busy  output  1  high in every state except IDLE.

## Operation
- Frame byte k is sensor_data[8k+7:8k], bit-reversed: sensor_data[8k] is the MSB. Byte 0 is humidity integer, byte 2 is temperature integer, byte 4 is the checksum.
- States are IDLE, START_SENSOR, WAIT_SENSOR, EVALUATE, SEND_CODE, SEND_DATA.
- IDLE: on command_valid with a valid command (0x00–0x02), latch the command and go to START_SENSOR.
  - An invalid command goes directly to SEND_CODE with code 0xFF and data 0x00. The sensor is not touched.
  - command_valid in any other state is ignored.
- START_SENSOR (1 cycle): sensor_enable=1 and sensor_reset=1, then go to WAIT_SENSOR.
- WAIT_SENSOR: sensor_enable=1, sensor_reset=0, and the timeout counter increments.
  - sensor_done is ignored in the first WAIT_SENSOR cycle.
  - After that, sensor_done=1 latches sensor_data and sensor_error, then goes to EVALUATE.
  - If the counter reaches TIMEOUT_CYCLES-1 without sensor_done, go to SEND_CODE with code 0x1E and data 0x00.
- EVALUATE (1 cycle): sensor_enable drops to 0.
  - sensor_error=1 gives code 0x1F, data 0x00.
  - A checksum failure gives code 0xEF, data 0x00.
  - Otherwise, by command: 0x00 gives code 0x08 / data 0x00; 0x01 gives 0x09 / byte 2; 0x02 gives 0x0A / byte 0.
- Checksum rule: (b0+b1+b2+b3) mod 256 == b4, computed with an 8-bit wrapping sum. Example: 0xFF+0x01+0x00+0x00 → 0x00.
- SEND_CODE, then SEND_DATA: present the byte with tx_valid=1 and advance on tx_valid&&tx_ready. After the data byte transfers, return to IDLE.
- sensor_enable is 0 in IDLE, EVALUATE, SEND_CODE and SEND_DATA. This freezes the sensor block between requests.

## Timing
- Reset values: sensor_enable=0, sensor_reset=0, tx_valid=0, tx_data=0x00, busy=0. State is IDLE and the counter is 0.
- Reset mid-operation returns to IDLE on the next edge. tx_valid drops even if a byte is mid-handshake, and no partial response resumes.
- sensor_enable and sensor_reset are Moore outputs decoded from the current state, with no register lag.
- Cycle view for a valid command strobed at cycle 0:
  - cycle 1: START_SENSOR.
  - cycle 2: first WAIT_SENSOR cycle; sensor_done is ignored.
  - the cycle after sensor_done is accepted: EVALUATE.
  - the following cycle: code byte presented.
- Invalid command: tx_valid rises at cycle 1.
- tx_data is stable while tx_valid=1 and tx_ready=0.
- After each transfer, tx_valid either stays high with the next byte or drops to 0 in IDLE.
- If tx_ready is held high, the code byte and data byte are accepted on consecutive cycles.
- sensor_done and timeout expiry in the same cycle: sensor_done wins.

## Configuration
- DHT11_CHECKSUM_CHECK_EN defined: the checksum rule is enforced, and a mismatch yields 0xEF.
- Not defined: the checksum is never checked and code 0xEF is never produced; the byte-4 compare logic is absent.

## Test plan
- Frame bytes 37 00 19 00 50 (each byte bit-reversed on sensor_data), command 0x01, tx_ready=1 → bytes 0x09 then 0x19; busy falls the cycle after the data byte transfers.
- Same frame, command 0x02 → 0x0A, 0x37; command 0x00 → 0x08, 0x00.
- Checksum byte 0x51, macro defined → 0xEF, 0x00. Macro undefined → 0x09, 0x19.
- sensor_done=1 with sensor_error=1 → 0x1F, 0x00. Sensor never completes (TIMEOUT_CYCLES=100) → 0x1E, 0x00 after 100 WAIT cycles.
- Command 0x07 → 0xFF, 0x00 with sensor_enable never asserted. tx_ready held low 10 cycles → tx_data holds 0xFF, and command_valid pulses during that time are ignored.
- Reset asserted mid-WAIT_SENSOR and mid-SEND_CODE → all outputs at reset values next cycle, and a new command afterwards completes normally.
